pe_mac_param: RTL



---
 rtl/pe_mac_pkg.sv | 69 ++++++
 rtl/pe_mac_param_if.sv | 27 ++
 rtl/pe_mac_mul_stage.sv | 37 +++
 rtl/pe_mac_param.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pe_mac_pkg.sv
// Shared types and helpers for the parametrised PE multiply-accumulate block:
// FSM encoding, saturating-add clip helper and the width sanity check.
package pe_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Widest accumulator the clip helper supports; sums carry one extra bit.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] val;
    } sat_t;

    function automatic bit widths_ok(input int acc_w, input int dw);
        return (acc_w >= 2 * dw) && (acc_w <= SAT_MAX_W);
    endfunction

    // sum_ext holds an (acc_w+1)-bit sum in its low bits; returns the
    // acc_w-bit clipped value plus an overflow indication.
    function automatic sat_t sat_acc(input logic [SAT_MAX_W:0] sum_ext,
                                     input int                 acc_w,
                                     input logic               signed_mode);
        sat_t       res;
        int         msb_pos;
        logic [6:0] top_idx;
        logic [6:0] msb_idx;
        logic       top_b;
        logic       msb_b;
        msb_pos = acc_w - 1;
        top_idx = acc_w[6:0];
        msb_idx = msb_pos[6:0];
        top_b   = sum_ext[top_idx];
        msb_b   = sum_ext[msb_idx];
        res.ovf = 1'b0;
        res.val = sum_ext[SAT_MAX_W-1:0];
        if (signed_mode) begin
            if (top_b != msb_b) begin
                res.ovf = 1'b1;
                for (int i = 0; i < SAT_MAX_W; i++) begin
                    if (i < msb_pos) begin
                        res.val[i] = ~top_b;
                    end else if (i == msb_pos) begin
                        res.val[i] = top_b;
                    end else begin
                        res.val[i] = 1'b0;
                    end
                end
            end else begin
                res.ovf = 1'b0;
            end
        end else begin
            if (top_b) begin
                res.ovf = 1'b1;
                for (int i = 0; i < SAT_MAX_W; i++) begin
                    res.val[i] = (i < acc_w) ? 1'b1 : 1'b0;
                end
            end else begin
                res.ovf = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_param_if.sv
// Request/result bundle between the conv controller and one PE MAC.
interface pe_mac_param_if #(
    parameter int N_TAPS = 27,
    parameter int DW     = 8,
    parameter int ACC_W  = 24
);
    logic                   start;
    logic                   signed_mode;
    logic                   acc_clear;
    logic [ACC_W-1:0]       bias;
    logic [N_TAPS*DW-1:0]   weights_flat;
    logic [N_TAPS*DW-1:0]   inputs_flat;
    logic [ACC_W-1:0]       mac_out;
    logic                   busy;
    logic                   done;
    logic                   ovf;

    modport master (
        output start, signed_mode, acc_clear, bias, weights_flat, inputs_flat,
        input  mac_out, busy, done, ovf
    );

    modport slave (
        input  start, signed_mode, acc_clear, bias, weights_flat, inputs_flat,
        output mac_out, busy, done, ovf
    );
endinterface

// File: rtl/pe_mac_mul_stage.sv
// Registered DW x DW multiplier, signed or unsigned per cycle, one-cycle latency.
module pe_mac_mul_stage #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            signed_mode,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] p_r,
    output logic            p_valid_r
);
    logic [2*DW-1:0] a_ext_s;
    logic [2*DW-1:0] b_ext_s;
    logic [2*DW-1:0] prod_s;

    // The low 2*DW bits of the extended product are exact in both modes.
    assign a_ext_s = {{DW{signed_mode & a[DW-1]}}, a};
    assign b_ext_s = {{DW{signed_mode & b[DW-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;

    // Product and valid pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r       <= '0;
            p_valid_r <= 1'b0;
        end else begin
            p_valid_r <= in_valid;
            if (in_valid) begin
                p_r <= prod_s;
            end else begin
                p_r <= p_r;
            end
        end
    end
endmodule

// File: rtl/pe_mac_param.sv
// Parametrised PE dot-product engine: one product per cycle, saturating
// accumulate with bias preload or continue-from-previous.
module pe_mac_param #(
    parameter int N_TAPS = 27,
    parameter int DW     = 8,
    parameter int ACC_W  = 24
) (
    input  logic           clk,
    input  logic           rst,
    pe_mac_param_if.slave  bus
);
    import pe_mac_pkg::*;

    localparam int              IDX_W    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

    if (!widths_ok(ACC_W, DW) || N_TAPS < 1 || N_TAPS > 64) begin : g_bad_params
        $error("pe_mac_param: need 2*DW <= ACC_W <= 64 and 1 <= N_TAPS <= 64");
    end

    state_t               state_r, state_nxt_s;
    logic                 accept_s, issue_s, finish_s;
    logic [IDX_W-1:0]     idx_r;
    logic [N_TAPS*DW-1:0] w_r, x_r;
    logic                 sgn_r;
    logic [ACC_W-1:0]     acc_r, mac_out_r;
    logic                 busy_r, done_r, ovf_r;
    logic [2*DW-1:0]      p_s;
    logic                 p_valid_s;
    logic [ACC_W:0]       p_ext_s, sum_s;
    logic [SAT_MAX_W:0]   sum_ext_s;
    sat_t                 sat_s;

    // Operands are consumed from the bottom of shift registers, so tap idx is always at [DW-1:0].
    pe_mac_mul_stage #(.DW(DW)) u_mul (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (issue_s),
        .signed_mode (sgn_r),
        .a           (w_r[DW-1:0]),
        .b           (x_r[DW-1:0]),
        .p_r         (p_s),
        .p_valid_r   (p_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and one-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        issue_s     = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!p_valid_s) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sign/zero extend the product and clip the sum into the accumulator range.
    always_comb begin
        p_ext_s             = {{(ACC_W + 1 - 2 * DW){sgn_r & p_s[2*DW-1]}}, p_s};
        sum_s               = {sgn_r & acc_r[ACC_W-1], acc_r} + p_ext_s;
        sum_ext_s           = '0;
        sum_ext_s[ACC_W:0]  = sum_s;
        sat_s               = sat_acc(sum_ext_s, ACC_W, sgn_r);
    end

    // Operand latch, tap sequencing and result/handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_r       <= '0;
            x_r       <= '0;
            sgn_r     <= 1'b0;
            idx_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            mac_out_r <= '0;
        end else begin
            done_r <= finish_s;
            if (accept_s) begin
                w_r    <= bus.weights_flat;
                x_r    <= bus.inputs_flat;
                sgn_r  <= bus.signed_mode;
                idx_r  <= '0;
                busy_r <= 1'b1;
            end else if (issue_s) begin
                w_r   <= w_r >> DW;
                x_r   <= x_r >> DW;
                idx_r <= idx_r + IDX_W'(1);
            end else if (finish_s) begin
                mac_out_r <= acc_r;
                busy_r    <= 1'b0;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Accumulator and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            acc_r <= bus.acc_clear ? bus.bias : acc_r;
            ovf_r <= 1'b0;
        end else if (p_valid_s) begin
            acc_r <= sat_s.val[ACC_W-1:0];
            ovf_r <= ovf_r | sat_s.ovf;
        end else begin
            acc_r <= acc_r;
        end
    end

    if (ACC_W < SAT_MAX_W) begin : g_sat_spare
        logic unused_sat_s;
        assign unused_sat_s = ^sat_s.val[SAT_MAX_W-1:ACC_W];
    end

    assign bus.mac_out = mac_out_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
endmodule
